rv_muxn_skid: RTL and testbench
===============================

Name: rv_muxn_skid

Overview:
- Parametrised N-input, W-bit operand select followed by a registered valid/ready output stage with a 2-entry skid buffer.
- Successor to the fixed 3-input 64-bit select used on the operand/writeback path, for pipelined datapaths needing backpressure.
- Selection happens on input accept; the selected word is presented one cycle later and held stable under stall.

Parameters:
- WIDTH, 64, data width of each input and of the output.
- NUM_IN, 3, number of selectable inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary select, sampled with in_data on accept.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat; driven only from state flops.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  select value that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts.
- sel_err  output  1  sticky out-of-range flag; present only with RV_MUXN_SELCHK_EN.

Behaviour:
- Reset: rst_n low at a clock edge clears state to EMPTY and zeroes the main and skid registers. Resulting values: out_valid=0, out_data=0, out_sel=0, in_ready=1 (from EMPTY), sel_err=0. Reset mid-transfer discards both buffered beats and issues no handshake.
- Accept: in_valid && in_ready at a clock edge. Drop: out_valid && out_ready at a clock edge.
- Select: word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_IN. Otherwise word = all-zero; never X.
- States: EMPTY, ONE (main full), TWO (main and skid full).
  - EMPTY: accept -> ONE, main <= word.
  - ONE, accept and drop -> ONE, main <= word.
  - ONE, accept only -> TWO, skid <= word.
  - ONE, drop only -> EMPTY.
  - ONE, neither -> ONE.
  - TWO, drop -> ONE, main <= skid.
  - TWO, no drop -> TWO.
- Outputs: out_valid = (state != EMPTY); in_ready = (state != TWO). out_data/out_sel always come from the main register.
- Latency: 1 cycle from accept to out_valid in EMPTY. Throughput is 1 beat/cycle while out_ready is held high.
- Stability: while out_valid && !out_ready, out_data and out_sel hold their values.
- Ordering: strictly FIFO; no beat is lost or duplicated.
- in_ready never depends combinationally on out_ready or in_valid.

Optional Feature:
- Macro: RV_MUXN_SELCHK_EN.
- Defined:
  - An accepted beat with in_sel >= NUM_IN is consumed (handshake completes) but never forwarded; the state machine treats it as no accept.
  - sel_err is set the cycle after that accept and stays set until reset.
- Undefined:
  - No sel_err port.
  - Out-of-range beats are forwarded as all-zero data carrying the offending out_sel.

Decomposition:
- Package rv_mux_pkg:
  - skid_state_e enum {EMPTY, ONE, TWO}.
  - Constants MUX_DEFAULT_WIDTH=64 and MUX_MAX_IN=16.
  - Function sel_in_range(sel, num_in).
- Sub-module rv_muxn_comb: purely combinational N-way select with the zero-on-out-of-range rule. Instantiated once on the input side.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1 after release; the first accept appears as out_valid the next cycle.
- Streaming: WIDTH=64, NUM_IN=3, inputs A=0x1111, B=0x2222, C=0x3333, sel 0,1,2 on consecutive cycles, out_ready=1 -> out_data 0x1111, 0x2222, 0x3333 on cycles 1-3; in_ready stays 1.
- Backpressure: out_ready=0 with 2 beats offered -> second beat goes to skid, in_ready=0 in TWO, out_data held. Releasing out_ready drains both in order with no loss or duplication.
- Out-of-range, macro off: sel=3 with NUM_IN=3 -> out_data=0, out_sel=3.
- Out-of-range, macro on: same stimulus -> beat absent from the output, sel_err=1 the next cycle and persisting until rst_n=0.
- Mid-operation reset and random stress:
  - Reset in TWO -> EMPTY, out_valid=0.
  - Then 10k cycles with random valid/ready, NUM_IN=5, WIDTH=32 -> scoreboard matches and in_ready never asserts in TWO.

Source files
------------

// File: rtl/rv_mux_pkg.sv
// Shared types and helpers for the N-way operand select with valid/ready skid output.
// Holds the skid occupancy states, default sizing constants and the select range test.
package rv_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int MUX_DEFAULT_WIDTH = 64;
  localparam int MUX_MAX_IN        = 16;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
    return sel < num_in;
  endfunction

endpackage

// File: rtl/rv_muxn_comb.sv
// Combinational N-way select of a WIDTH-bit word; zero-latency, no flow control.
// A select at or beyond NUM_IN yields an all-zero word rather than X.
module rv_muxn_comb
  import rv_mux_pkg::*;
#(
  parameter  int WIDTH  = MUX_DEFAULT_WIDTH,
  parameter  int NUM_IN = 3,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word
);

  // Unmatched selects fall through to the zero default.
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (SEL_W'(k) == sel) word = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/rv_muxn_skid.sv
// N-input select into a registered 2-entry skid output; 1 cycle accept-to-valid, full rate.
// in_ready comes only from state (drops in TWO); RV_MUXN_SELCHK_EN drops out-of-range beats and adds sel_err.
module rv_muxn_skid
  import rv_mux_pkg::*;
#(
  parameter  int WIDTH  = MUX_DEFAULT_WIDTH,
  parameter  int NUM_IN = 3,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef RV_MUXN_SELCHK_EN
  ,
  output logic                    sel_err
`endif
);

  skid_state_e      state;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] main_sel;
  logic [SEL_W-1:0] skid_sel;
  logic             acc;
  logic             drop;
  logic             push;

  rv_muxn_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .in_data (in_data),
    .sel     (in_sel),
    .word    (word)
  );

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_sel   = main_sel;

  assign acc  = in_valid && in_ready;
  assign drop = out_valid && out_ready;

`ifdef RV_MUXN_SELCHK_EN
  // Out-of-range beats complete their handshake but never enter the buffer.
  assign push = acc && sel_in_range(32'(in_sel), NUM_IN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (acc && !sel_in_range(32'(in_sel), NUM_IN)) begin
      sel_err <= 1'b1;
    end
  end
`else
  assign push = acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state     <= ONE;
            main_data <= word;
            main_sel  <= in_sel;
          end
        end
        ONE: begin
          if (push && drop) begin
            main_data <= word;
            main_sel  <= in_sel;
          end else if (push) begin
            state     <= TWO;
            skid_data <= word;
            skid_sel  <= in_sel;
          end else if (drop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (drop) begin
            state     <= ONE;
            main_data <= skid_data;
            main_sel  <= skid_sel;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muxn_skid.sv
// Directed checks on a 3x64 instance plus randomized queue-model scoreboard on a 5x32 instance.
// Honors RV_MUXN_SELCHK_EN for the out-of-range behaviour and the sel_err port.
module tb_rv_muxn_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [191:0] a_in_data;
  logic [1:0]   a_in_sel;
  logic         a_in_valid;
  logic         a_in_ready;
  logic [63:0]  a_out_data;
  logic [1:0]   a_out_sel;
  logic         a_out_valid;
  logic         a_out_ready;

  logic [159:0] b_in_data;
  logic [2:0]   b_in_sel;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [31:0]  b_out_data;
  logic [2:0]   b_out_sel;
  logic         b_out_valid;
  logic         b_out_ready;

`ifdef RV_MUXN_SELCHK_EN
  logic a_sel_err;
  logic b_sel_err;
`endif

  rv_muxn_skid dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
`ifdef RV_MUXN_SELCHK_EN
    ,
    .sel_err   (a_sel_err)
`endif
  );

  rv_muxn_skid #(.WIDTH(32), .NUM_IN(5)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
`ifdef RV_MUXN_SELCHK_EN
    ,
    .sel_err   (b_sel_err)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected word for the 5x32 instance straight from the select rule.
  function automatic logic [31:0] ref_word(input logic [159:0] d, input logic [2:0] s);
    int k;
    k = int'(s);
    if (k < 5) return d[k*32 +: 32];
    return 32'h0;
  endfunction

  logic [34:0] q[$];
  logic        m_acc;
  logic        m_drop;
  logic        m_fwd;

  initial begin
    rst_n       = 1'b0;
    a_in_data   = {64'h3333, 64'h2222, 64'h1111};
    a_in_sel    = 2'd0;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    b_in_data   = '0;
    b_in_sel    = 3'd0;
    b_in_valid  = 1'b1;
    b_out_ready = 1'b0;
    @(negedge clk);

    repeat (3) begin
      tick();
      check_eq("rst_hold_out_valid", a_out_valid, 1'b0);
    end
    rst_n      = 1'b1;
    b_in_valid = 1'b0;
    check_eq("rst_out_valid", a_out_valid, 1'b0);
    check_eq("rst_out_data", a_out_data, 64'h0);
    check_eq("rst_out_sel", a_out_sel, 2'd0);
    check_eq("rst_in_ready", a_in_ready, 1'b1);
    check_eq("rst_b_out_valid", b_out_valid, 1'b0);
`ifdef RV_MUXN_SELCHK_EN
    check_eq("rst_sel_err", a_sel_err, 1'b0);
`endif

    // Streaming A, B, C back to back with the sink always ready.
    for (int i = 0; i < 3; i++) begin
      a_in_sel = 2'(i);
      tick();
      check_eq("stream_out_valid", a_out_valid, 1'b1);
      check_eq("stream_out_data", a_out_data, 64'h1111 * (i + 1));
      check_eq("stream_out_sel", a_out_sel, 64'(i));
      check_eq("stream_in_ready", a_in_ready, 1'b1);
    end
    a_in_valid = 1'b0;
    tick();
    check_eq("stream_drained", a_out_valid, 1'b0);

    // Backpressure: fill main then skid, offer a third beat that must be refused.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd0;
    tick();
    check_eq("bp_one_data", a_out_data, 64'h1111);
    check_eq("bp_one_in_ready", a_in_ready, 1'b1);
    a_in_sel = 2'd1;
    tick();
    check_eq("bp_two_in_ready", a_in_ready, 1'b0);
    check_eq("bp_two_data", a_out_data, 64'h1111);
    a_in_sel = 2'd2;
    tick();
    check_eq("bp_hold_data", a_out_data, 64'h1111);
    check_eq("bp_hold_sel", a_out_sel, 2'd0);
    check_eq("bp_hold_in_ready", a_in_ready, 1'b0);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    check_eq("bp_drain1_valid", a_out_valid, 1'b1);
    check_eq("bp_drain1_data", a_out_data, 64'h2222);
    check_eq("bp_drain1_sel", a_out_sel, 2'd1);
    check_eq("bp_drain1_in_ready", a_in_ready, 1'b1);
    tick();
    check_eq("bp_drain2_valid", a_out_valid, 1'b0);

    // Out-of-range select on the 3-input instance.
    a_in_valid = 1'b1;
    a_in_sel   = 2'd3;
    tick();
    a_in_valid = 1'b0;
`ifdef RV_MUXN_SELCHK_EN
    check_eq("oor_dropped", a_out_valid, 1'b0);
    check_eq("oor_sel_err", a_sel_err, 1'b1);
`else
    check_eq("oor_out_valid", a_out_valid, 1'b1);
    check_eq("oor_out_data", a_out_data, 64'h0);
    check_eq("oor_out_sel", a_out_sel, 2'd3);
`endif
    tick();
    check_eq("oor_after_valid", a_out_valid, 1'b0);

    // Fill the 5-input instance to TWO, then reset it mid-transfer.
    for (int k = 0; k < 5; k++) b_in_data[k*32 +: 32] = $urandom;
    b_in_valid = 1'b1;
    b_in_sel   = 3'd1;
    tick();
    tick();
    check_eq("midrst_pre_in_ready", b_in_ready, 1'b0);
    check_eq("midrst_pre_out_valid", b_out_valid, 1'b1);
`ifdef RV_MUXN_SELCHK_EN
    check_eq("sel_err_sticky", a_sel_err, 1'b1);
`endif
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    b_in_valid = 1'b0;
    check_eq("midrst_out_valid", b_out_valid, 1'b0);
    check_eq("midrst_in_ready", b_in_ready, 1'b1);
    check_eq("midrst_out_data", b_out_data, 32'h0);
`ifdef RV_MUXN_SELCHK_EN
    check_eq("midrst_sel_err", a_sel_err, 1'b0);
`endif

    // Random stress against a depth-2 FIFO model.
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check_eq("rnd_in_ready", b_in_ready, q.size() < 2);
      check_eq("rnd_out_valid", b_out_valid, q.size() != 0);
      if (q.size() != 0) begin
        check_eq("rnd_out_data", b_out_data, q[0][31:0]);
        check_eq("rnd_out_sel", b_out_sel, q[0][34:32]);
      end
      for (int k = 0; k < 5; k++) b_in_data[k*32 +: 32] = $urandom;
      b_in_sel    = 3'($urandom_range(0, 7));
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      m_acc  = b_in_valid && (q.size() < 2);
      m_drop = (q.size() != 0) && b_out_ready;
`ifdef RV_MUXN_SELCHK_EN
      m_fwd = (b_in_sel < 3'd5);
`else
      m_fwd = 1'b1;
`endif
      @(posedge clk);
      if (m_drop) void'(q.pop_front());
      if (m_acc && m_fwd) q.push_back({b_in_sel, ref_word(b_in_data, b_in_sel)});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
